// File: rtl/lfsr_test_controller_if.sv
// Signal bundle between the LFSR characterisation controller, the LFSR under test
// and the top-level test/status logic.
interface lfsr_test_controller_if #(
  parameter int N = 14
);
  // Handshake: start is a one-cycle request accepted only while idle (!busy && !done).
  // Results are valid while done is high and are held until ack, which returns to idle.
  // abort cancels an in-flight run (busy); it is a no-op otherwise.
  logic         start;
  logic         abort;
  logic         ack;
  logic         lfsr_msb;
  logic         lfsr_max_tick;
  logic         lfsr_load;
  logic         lfsr_en;
  logic         busy;
  logic         done;
  logic         pass;
  logic         timeout;
  logic [N-1:0] ones_count;
  logic [N-1:0] zeros_count;
  logic [N-1:0] period;

  modport master (
    output start, abort, ack, lfsr_msb, lfsr_max_tick,
    input  lfsr_load, lfsr_en, busy, done, pass, timeout,
    input  ones_count, zeros_count, period
  );

  modport slave (
    input  start, abort, ack, lfsr_msb, lfsr_max_tick,
    output lfsr_load, lfsr_en, busy, done, pass, timeout,
    output ones_count, zeros_count, period
  );
endinterface

// File: rtl/lfsr_test_controller.sv
// Runs one full-period characterisation of an N-bit maximal LFSR: load seed, count
// MSB ones/zeros until the state returns to the seed, then judge period and balance.
module lfsr_test_controller #(
  parameter int N = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  lfsr_test_controller_if.slave  bus,
  output logic [2:0]             o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [N-1:0] C_FULL    = {N{1'b1}};
  localparam logic [N-1:0] C_HALF    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] C_HALF_M1 = {1'b0, {(N-1){1'b1}}};

  state_t       r_state;
  state_t       w_next;
  logic [N-1:0] r_ones;
  logic [N-1:0] r_zeros;
  logic [N-1:0] r_period;
  logic         r_pass;
  logic         r_timeout;

  logic         w_clear;
  logic         w_count;
  logic         w_set_timeout;
  logic         w_eval;
  logic         w_abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_clear       = 1'b0;
    w_count       = 1'b0;
    w_set_timeout = 1'b0;
    w_eval        = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next  = S_LOAD;
          w_clear = 1'b1;
        end
      end
      S_LOAD: begin
        if (bus.abort) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        // The seed is seen with period==0 on the first RUN cycle; only a later
        // max_tick marks the return to seed.
        if (bus.abort) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else if (bus.lfsr_max_tick && (r_period != '0)) begin
          w_next = S_CHECK;
        end else if (r_period == C_FULL) begin
          w_next        = S_CHECK;
          w_set_timeout = 1'b1;
        end else begin
          w_count = 1'b1;
        end
      end
      S_CHECK: begin
        if (bus.abort) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else begin
          w_next = S_DONE;
          w_eval = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.ack) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ones    <= '0;
      r_zeros   <= '0;
      r_period  <= '0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_clear) begin
        r_ones    <= '0;
        r_zeros   <= '0;
        r_period  <= '0;
        r_pass    <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_abort) begin
        r_pass    <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_count) begin
        if (bus.lfsr_msb) begin
          r_ones <= r_ones + 1'b1;
        end else begin
          r_zeros <= r_zeros + 1'b1;
        end
        r_period <= r_period + 1'b1;
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
      if (w_eval) begin
        r_pass <= !r_timeout && (r_period == C_FULL) &&
                  (r_ones == C_HALF) && (r_zeros == C_HALF_M1);
      end
    end
  end

  // Enable drops in the abort cycle so the LFSR does not advance past the frozen counts.
  assign bus.lfsr_load   = (r_state == S_LOAD);
  assign bus.lfsr_en     = (r_state == S_RUN) && !bus.abort;
  assign bus.busy        = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_CHECK);
  assign bus.done        = (r_state == S_DONE);
  assign bus.pass        = r_pass;
  assign bus.timeout     = r_timeout;
  assign bus.ones_count  = r_ones;
  assign bus.zeros_count = r_zeros;
  assign bus.period      = r_period;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_lfsr_test_controller.sv
// Bench for lfsr_test_controller: a 4-bit LFSR environment model feeds the controller,
// expected results are queued at start and checked when done rises.
module tb_lfsr_test_controller;

  localparam int N = 4;
  localparam int W = 3*N + 10;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;

  lfsr_test_controller_if #(.N(N)) bus();

  lfsr_test_controller #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got time limit expired expected run to finish");
    $fatal(1, "watchdog");
  end

  // ---------------- LFSR environment ----------------
  // cyc_len: 15 = true maximal LFSR (max_tick when state==seed), 0 = max_tick stuck low,
  // other = max_tick returns every cyc_len steps after load.
  logic [3:0] m_state = 4'd0;
  logic [3:0] m_seed  = 4'd1;
  int         m_k     = 0;
  int         m_len   = 15;

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  always @(posedge clk) begin
    if (bus.lfsr_load) begin
      m_state <= m_seed;
      m_k     <= 0;
    end else if (bus.lfsr_en) begin
      m_state <= lfsr_next(m_state);
      m_k     <= m_k + 1;
    end
  end

  assign bus.lfsr_msb      = m_state[3];
  assign bus.lfsr_max_tick = (m_len == 15) ? (m_state == m_seed) :
                             (m_len == 0)  ? 1'b0 : ((m_k % m_len) == 0);

  // ---------------- reference model ----------------
  function automatic int msb_ones(input logic [3:0] seed, input int steps);
    logic [3:0] s;
    int n;
    s = seed;
    n = 0;
    for (int i = 0; i < steps; i++) begin
      n += int'(s[3]);
      s = lfsr_next(s);
    end
    return n;
  endfunction

  function automatic logic [W-1:0] expect_run(input int len, input logic [3:0] seed);
    int p, ones, zeros, lat;
    logic to, ps;
    p     = (len == 0) ? 15 : len;
    ones  = msb_ones(seed, p);
    zeros = p - ones;
    to    = (len == 0);
    ps    = !to && (p == 15) && (ones == 8) && (zeros == 7);
    lat   = 1 + (p + 1) + 1;
    return {lat[7:0], ps, to, p[3:0], ones[3:0], zeros[3:0]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   busy_cnt  = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.busy) busy_cnt++;
      else if (!bus.done) busy_cnt = 0;
      if (bus.done && !prev_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency",     busy_cnt,                 int'(e[21:14]));
          chk("pass",        int'(bus.pass),           int'(e[13]));
          chk("timeout",     int'(bus.timeout),        int'(e[12]));
          chk("period",      int'(bus.period),         int'(e[11:8]));
          chk("ones_count",  int'(bus.ones_count),     int'(e[7:4]));
          chk("zeros_count", int'(bus.zeros_count),    int'(e[3:0]));
        end
      end
      prev_done = bus.done;
      if (bus.lfsr_load || bus.lfsr_en)
        chk("load_en_exclusive", int'(bus.lfsr_load && bus.lfsr_en), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!bus.done && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("wait_done_bound", 0, 1);
  endtask

  task automatic run(input int len, input bit start_while_busy);
    logic [3:0]   seed;
    logic [W-1:0] e;
    seed   = 4'($urandom_range(1, 15));
    m_seed = seed;
    m_len  = len;
    e = expect_run(len, seed);
    exp_q.push_back(e);
    pulse_start();
    if (start_while_busy) begin
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      chk("start_busy_no_load", int'(bus.lfsr_load), 0);
      chk("start_busy_busy",    int'(bus.busy), 1);
    end
    wait_done(200);
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    chk("start_in_done_done", int'(bus.done), 1);
    chk("start_in_done_load", int'(bus.lfsr_load), 0);
    bus.ack = 1'b1;
    @(negedge clk) bus.ack = 1'b0;
    chk("ack_done_low",    int'(bus.done), 0);
    chk("ack_busy_low",    int'(bus.busy), 0);
    chk("ack_period_held", int'(bus.period), int'(e[11:8]));
    chk("ack_pass_held",   int'(bus.pass), int'(e[13]));
  endtask

  task automatic abort_test();
    logic [3:0] seed;
    int ones, n;
    seed   = 4'($urandom_range(1, 15));
    m_seed = seed;
    m_len  = 15;
    ones   = msb_ones(seed, 5);
    pulse_start();
    n = 0;
    while (!bus.lfsr_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_run", int'(bus.lfsr_en), 1);
    repeat (5) @(negedge clk);
    bus.abort = 1'b1;
    #1 chk("abort_en_low", int'(bus.lfsr_en), 0);
    @(negedge clk) bus.abort = 1'b0;
    chk("abort_idle_busy",  int'(bus.busy), 0);
    chk("abort_idle_done",  int'(bus.done), 0);
    chk("abort_period",     int'(bus.period), 5);
    chk("abort_ones",       int'(bus.ones_count), ones);
    chk("abort_zeros",      int'(bus.zeros_count), 5 - ones);
    chk("abort_pass",       int'(bus.pass), 0);
    chk("abort_timeout",    int'(bus.timeout), 0);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", int'(bus.busy || bus.done), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},    int'(bus.busy), 0);
    chk({tag, "_done"},    int'(bus.done), 0);
    chk({tag, "_pass"},    int'(bus.pass), 0);
    chk({tag, "_timeout"}, int'(bus.timeout), 0);
    chk({tag, "_load"},    int'(bus.lfsr_load), 0);
    chk({tag, "_en"},      int'(bus.lfsr_en), 0);
    chk({tag, "_ones"},    int'(bus.ones_count), 0);
    chk({tag, "_zeros"},   int'(bus.zeros_count), 0);
    chk({tag, "_period"},  int'(bus.period), 0);
  endtask

  task automatic reset_mid_run();
    m_seed = 4'($urandom_range(1, 15));
    m_len  = 15;
    exp_q.push_back(expect_run(15, m_seed));
    pulse_start();
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_reset");
    exp_q.delete();
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.ack   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    run(15, 1'b0);
    run(0,  1'b0);
    run(6,  1'b0);
    run(15, 1'b1);
    abort_test();
    run(15, 1'b0);
    for (int i = 0; i < 4; i++) run($urandom_range(2, 14), 1'b0);
    run(0, 1'b0);
    reset_mid_run();
    run(15, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
